dm_access_unit: RTL
===================

Name: dm_access_unit

Overview:
- Memory-stage data-memory access unit; consumes the EX/DM pipeline register outputs (ALU result as address, rs2 read data, instruction, control signals).
- Drives a valid/ready request channel and a response channel to data memory.
- Handles byte-lane alignment, sign/zero extension and stalling of the pipeline while an access is outstanding.

Parameters:
- XLEN, 32, data and address width (matches `REG_BUS`).
- BE_W, XLEN/8, byte-enable width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-low; sampled on posedge clk only.
- m_alu_y  in  XLEN  effective address from EX/DM register.
- m_rrd2  in  XLEN  store data from EX/DM register.
- m_funct3  in  3  instr[14:12] from EX/DM register.
- m_mem_read  in  1  load request, decoded field of controlsgs_t.
- m_mem_write  in  1  store request, decoded field of controlsgs_t.
- dm_req_valid  out  1  request valid.
- dm_req_ready  in  1  memory accepts request.
- dm_req_we  out  1  1 = write.
- dm_req_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00}).
- dm_req_wdata  out  XLEN  lane-replicated store data.
- dm_req_be  out  BE_W  byte enables.
- dm_rsp_valid  in  1  read data valid (one cycle pulse).
- dm_rsp_rdata  in  XLEN  raw word read data.
- m_load_data  out  XLEN  extended load result.
- m_stall  out  1  hold IF/ID/EX/DM registers (drives their enable low).
- m_misaligned  out  1  misaligned access flag (see optional feature).

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE. On reset low: state=IDLE; all registered outputs (dm_req_*, m_load_data, m_misaligned) = 0.
- Access = m_mem_read | m_mem_write. If both are high, write wins.
- IDLE:
  - On access: latch addr, aligned wdata, be, we, funct3, addr[1:0]; go to REQ.
  - No access: stay in IDLE.
- REQ:
  - dm_req_valid=1; all request fields stable until handshake.
  - On dm_req_ready: store goes to DONE; load goes to RSP. Otherwise hold.
- RSP:
  - Wait for dm_rsp_valid.
  - On dm_rsp_valid: shift rdata right by offset*8, extend per funct3, register into m_load_data; go to DONE.
  - dm_rsp_valid in any other state is ignored.
- DONE: one cycle, stall low so the pipeline advances; go to IDLE.
- m_stall = (IDLE & access) | REQ | RSP. It is combinational, so the stall asserts in the same cycle the access appears.
- Minimum latency, with ready/rsp returning immediately:
  - Store: 3 cycles (IDLE, REQ, DONE).
  - Load: 4 cycles (IDLE, REQ, RSP, DONE).
- Store lanes:
  - SB: be=4'b0001<<off; wdata={4{b}}.
  - SH: be=4'b0011<<{off[1],0}; wdata={2{h}}.
  - SW: be=4'hF.
- Loads use be=4'hF. Extension by funct3:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011/110/111 are treated as word access.
- m_load_data holds its value until the next load completes. Stores do not change it.
- Reset low mid-access: abandon the access and return to IDLE next edge. Memory must tolerate a dropped valid in this case only.

Optional Feature:
- Macro DM_MISALIGN_TRAP_EN.
- Defined:
  - Half access with off[0]=1, or word access with off!=0, does not enter REQ.
  - The FSM goes IDLE→DONE; m_misaligned=1 for that DONE cycle, else 0.
  - m_load_data is unchanged, no request is issued, and m_stall asserts for exactly one cycle.
- Undefined:
  - Offset bits are masked: half uses {off[1],0}, word uses 0. The access proceeds normally.
  - m_misaligned is tied 0.

Decomposition:
- Shared package (defines.sv / controlsgs package): XLEN via `REG_BUS`, funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), dm_state_t enum.
- One sub-module is natural: dm_lane_align. It is combinational and maps offset/funct3/data to be/wdata for stores and to the extended result for loads. The FSM stays in dm_access_unit.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, ready held high → req addr=0x100, be=4'hF, wdata=0xDEADBEEF; m_stall high 2 cycles then low in DONE.
- SB addr=0x103, data=0x000000A5 → be=4'b1000, wdata=0xA5A5A5A5, addr=0x100.
- LB addr=0x202, rsp rdata=0x12F45678 → m_load_data=0xFFFFFFF4. Same access as LBU → 0x000000F4. LHU addr=0x202 → 0x000012F4.
- LW with dm_req_ready low 3 cycles, then rsp 2 cycles after handshake:
  - dm_req_* held stable throughout; m_stall stays high until DONE.
  - m_load_data updates only on rsp.
- Reset low during RSP of a load → next edge state=IDLE, dm_req_valid=0, m_load_data=0, m_stall follows inputs only.
- LW addr=0x101:
  - With DM_MISALIGN_TRAP_EN: no dm_req_valid, m_misaligned=1 one cycle.
  - Without: request issued to addr=0x100, m_misaligned=0.

Source files
------------

// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: bus width, funct3 load/store codes,
// FSM state type and the offset-masking helper used for both store lanes and load extraction.
`ifndef REG_BUS
`define REG_BUS 32
`endif

package dm_access_unit_pkg;

  localparam int XLEN_DEF = `REG_BUS;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} dm_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} dm_size_t;

  // funct3[1:0] alone decides the size; 011/110/111 fall through to word.
  function automatic dm_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] off, input dm_size_t sz);
    case (sz)
      SZ_B:    return off;
      SZ_H:    return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data, misalignment
// detection, and load-side shift plus sign/zero extension.
module dm_lane_align
  import dm_access_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int BE_W = XLEN / 8
) (
  input  logic [1:0]      st_off,
  input  logic [2:0]      st_funct3,
  input  logic            st_we,
  input  logic [XLEN-1:0] st_data,
  output logic [BE_W-1:0] st_be,
  output logic [XLEN-1:0] st_wdata,
  output logic            misaligned,
  input  logic [1:0]      ld_off,
  input  logic [2:0]      ld_funct3,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_result
);

  logic [1:0]      st_eff, ld_eff;
  logic [XLEN-1:0] shifted;

  always_comb begin
    st_eff     = align_off(st_off, f3_size(st_funct3));
    misaligned = (st_off != st_eff);
    st_be      = '1;
    st_wdata   = st_data;
    if (st_we) begin
      case (f3_size(st_funct3))
        SZ_B: begin
          st_be    = BE_W'(1) << st_eff;
          st_wdata = {BE_W{st_data[7:0]}};
        end
        SZ_H: begin
          st_be    = BE_W'(3) << st_eff;
          st_wdata = {(BE_W/2){st_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_eff  = align_off(ld_off, f3_size(ld_funct3));
    shifted = ld_rdata >> {ld_eff, 3'b000};
    case (ld_funct3)
      F3_B:    ld_result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_H:    ld_result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_W:    ld_result = shifted;
      default: ld_result = shifted;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Memory-stage access sequencer: IDLE -> REQ -> (RSP) -> DONE, stalling the pipeline meanwhile.
// Define DM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking the offset.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] m_alu_y,
  input  logic [XLEN-1:0] m_rrd2,
  input  logic [2:0]      m_funct3,
  input  logic            m_mem_read,
  input  logic            m_mem_write,
  output logic            dm_req_valid,
  input  logic            dm_req_ready,
  output logic            dm_req_we,
  output logic [XLEN-1:0] dm_req_addr,
  output logic [XLEN-1:0] dm_req_wdata,
  output logic [BE_W-1:0] dm_req_be,
  input  logic            dm_rsp_valid,
  input  logic [XLEN-1:0] dm_rsp_rdata,
  output logic [XLEN-1:0] m_load_data,
  output logic            m_stall,
  output logic            m_misaligned
);

`ifdef DM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  dm_state_t       state, state_n;
  logic            access, misaligned, trap_hit, start;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic [BE_W-1:0] st_be;
  logic [XLEN-1:0] st_wdata, ld_result;

  assign access   = m_mem_read | m_mem_write;
  assign trap_hit = TRAP_EN & misaligned;
  assign start    = (state == IDLE) & access & ~trap_hit;
  assign m_stall  = ((state == IDLE) & access) | (state == REQ) | (state == RSP);

  // Store side sees the live EX/DM fields; load side uses the fields captured at request time.
  dm_lane_align #(.XLEN(XLEN), .BE_W(BE_W)) u_align (
    .st_off     (m_alu_y[1:0]),
    .st_funct3  (m_funct3),
    .st_we      (m_mem_write),
    .st_data    (m_rrd2),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .misaligned (misaligned),
    .ld_off     (off_q),
    .ld_funct3  (f3_q),
    .ld_rdata   (dm_rsp_rdata),
    .ld_result  (ld_result)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (access) state_n = trap_hit ? DONE : REQ;
      REQ:     if (dm_req_ready) state_n = dm_req_we ? DONE : RSP;
      RSP:     if (dm_rsp_valid) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      dm_req_valid <= 1'b0;
      dm_req_we    <= 1'b0;
      dm_req_addr  <= '0;
      dm_req_wdata <= '0;
      dm_req_be    <= '0;
      m_load_data  <= '0;
      m_misaligned <= 1'b0;
      off_q        <= '0;
      f3_q         <= '0;
    end else begin
      state        <= state_n;
      dm_req_valid <= (state_n == REQ);
      m_misaligned <= (state == IDLE) & access & trap_hit;
      if (start) begin
        dm_req_we    <= m_mem_write;
        dm_req_addr  <= {m_alu_y[XLEN-1:2], 2'b00};
        dm_req_wdata <= st_wdata;
        dm_req_be    <= st_be;
        off_q        <= m_alu_y[1:0];
        f3_q         <= m_funct3;
      end
      if ((state == RSP) & dm_rsp_valid) m_load_data <= ld_result;
    end
  end

endmodule
